// File: rtl/spin_cycle_sequencer.sv
// spin_cycle_sequencer
//
// Sequences one run of an analog spin macro. A run has cfg_icon_last_i
// iterations. Each iteration fetches a spin vector (or reuses the previous
// one when flips are disabled), drives the macro's write and compute
// enables for programmed cycle counts, waits out a synchronizer delay, and
// then presents one result through a valid/ready handshake.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   en_i                    enable; low aborts a run and returns to idle
//   start_i                 starts a run (only in idle)
//   cfg_*_i                 run configuration, captured when a run starts
//   spin_valid_i/spin_i     next spin vector; spin_ready_o is high while fetching
//   spin_o                  latched spin vector driven to the macro
//   spin_write_en_o         macro write-phase enable
//   compute_en_o            macro compute-phase enable
//   result_valid_o/_ready_i per-iteration result handshake
//   icon_addr_o             current iteration index
//   busy_o, done_o          run in progress; one-cycle end-of-run pulse
module spin_cycle_sequencer #(
    parameter int unsigned NUM_SPIN         = 256,
    parameter int unsigned COUNTER_BITWIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cyc_write_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cyc_compute_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_sync_num_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_icon_last_i,
    input  logic                        cfg_flip_disable_i,
    input  logic                        cfg_analog_en_i,
    input  logic                        spin_valid_i,
    input  logic [NUM_SPIN-1:0]         spin_i,
    output logic                        spin_ready_o,
    output logic [NUM_SPIN-1:0]         spin_o,
    output logic                        spin_write_en_o,
    output logic                        compute_en_o,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [COUNTER_BITWIDTH-1:0] icon_addr_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned CW = COUNTER_BITWIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StCompute,
        StSync,
        StOutput,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       icon_q, icon_d;
    logic [NUM_SPIN-1:0] spin_q, spin_d;

    // Shadow copies of the configuration, frozen for the duration of a run.
    logic [CW-1:0] cyc_write_q, cyc_write_d;
    logic [CW-1:0] cyc_compute_q, cyc_compute_d;
    logic [CW-1:0] sync_num_q, sync_num_d;
    logic [CW-1:0] icon_last_q, icon_last_d;
    logic          flip_disable_q, flip_disable_d;
    logic          analog_en_q, analog_en_d;

    // Terminal counts. A programmed 0 behaves as 1 for write, compute and the
    // iteration count, so the terminal value is simply 0 in that case.
    logic [CW-1:0] write_last, compute_last, sync_last, icon_final;

    always_comb begin
        write_last   = (cyc_write_q == '0)   ? '0 : cyc_write_q - CW'(1);
        compute_last = (cyc_compute_q == '0) ? '0 : cyc_compute_q - CW'(1);
        sync_last    = (sync_num_q == '0)    ? '0 : sync_num_q - CW'(1);
        icon_final   = (icon_last_q == '0)   ? '0 : icon_last_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            icon_q         <= '0;
            spin_q         <= '0;
            cyc_write_q    <= '0;
            cyc_compute_q  <= '0;
            sync_num_q     <= '0;
            icon_last_q    <= '0;
            flip_disable_q <= 1'b0;
            analog_en_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            icon_q         <= icon_d;
            spin_q         <= spin_d;
            cyc_write_q    <= cyc_write_d;
            cyc_compute_q  <= cyc_compute_d;
            sync_num_q     <= sync_num_d;
            icon_last_q    <= icon_last_d;
            flip_disable_q <= flip_disable_d;
            analog_en_q    <= analog_en_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        icon_d         = icon_q;
        spin_d         = spin_q;
        cyc_write_d    = cyc_write_q;
        cyc_compute_d  = cyc_compute_q;
        sync_num_d     = sync_num_q;
        icon_last_d    = icon_last_q;
        flip_disable_d = flip_disable_q;
        analog_en_d    = analog_en_q;

        if (!en_i) begin
            // Abort wins over any handshake completing in the same cycle.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        cyc_write_d    = cfg_cyc_write_i;
                        cyc_compute_d  = cfg_cyc_compute_i;
                        sync_num_d     = cfg_sync_num_i;
                        icon_last_d    = cfg_icon_last_i;
                        flip_disable_d = cfg_flip_disable_i;
                        analog_en_d    = cfg_analog_en_i;
                        icon_d         = '0;
                        cnt_d          = '0;
                        state_d        = StFetch;
                    end
                end
                StFetch: begin
                    if (spin_valid_i) begin
                        spin_d  = spin_i;
                        cnt_d   = '0;
                        state_d = analog_en_q ? StWrite : StOutput;
                    end
                end
                StWrite: begin
                    if (cnt_q == write_last) begin
                        cnt_d   = '0;
                        state_d = StCompute;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StCompute: begin
                    if (cnt_q == compute_last) begin
                        cnt_d   = '0;
                        state_d = (sync_num_q == '0) ? StOutput : StSync;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StSync: begin
                    if (cnt_q == sync_last) begin
                        cnt_d   = '0;
                        state_d = StOutput;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StOutput: begin
                    if (result_ready_i) begin
                        cnt_d = '0;
                        if (icon_q == icon_final) begin
                            state_d = StDone;
                        end else begin
                            icon_d = icon_q + CW'(1);
                            // With flips disabled the latched vector is reused;
                            // in bypass mode there is no write phase to return to.
                            if (!flip_disable_q) begin
                                state_d = StFetch;
                            end else if (analog_en_q) begin
                                state_d = StWrite;
                            end else begin
                                state_d = StOutput;
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign spin_ready_o    = (state_q == StFetch);
    assign spin_write_en_o = (state_q == StWrite);
    assign compute_en_o    = (state_q == StCompute);
    assign result_valid_o  = (state_q == StOutput);
    assign done_o          = (state_q == StDone);
    assign busy_o          = (state_q != StIdle);
    assign spin_o          = spin_q;
    assign icon_addr_o     = icon_q;

endmodule

// File: tb/tb_spin_cycle_sequencer.sv
// Randomised bench for spin_cycle_sequencer. Expected behaviour comes from a
// queue of phases (fetch, write, compute, sync, output, done) built from the
// run configuration; each cycle the head phase gives the expected outputs.
module tb_spin_cycle_sequencer;

    localparam int NS = 64;
    localparam int CW = 16;

    localparam int KF = 0;
    localparam int KW = 1;
    localparam int KC = 2;
    localparam int KS = 3;
    localparam int KO = 4;
    localparam int KD = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cyc_write = '0;
    logic [CW-1:0] cyc_compute = '0;
    logic [CW-1:0] sync_num = '0;
    logic [CW-1:0] icon_last = '0;
    logic          flip_disable = 1'b0;
    logic          analog_en = 1'b0;
    logic          spin_valid = 1'b0;
    logic [NS-1:0] spin_in = '0;
    logic          spin_ready;
    logic [NS-1:0] spin_out;
    logic          spin_write_en;
    logic          compute_en;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [CW-1:0] icon_addr;
    logic          busy;
    logic          done;

    spin_cycle_sequencer #(
        .NUM_SPIN        (NS),
        .COUNTER_BITWIDTH(CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .en_i              (en),
        .start_i           (start),
        .cfg_cyc_write_i   (cyc_write),
        .cfg_cyc_compute_i (cyc_compute),
        .cfg_sync_num_i    (sync_num),
        .cfg_icon_last_i   (icon_last),
        .cfg_flip_disable_i(flip_disable),
        .cfg_analog_en_i   (analog_en),
        .spin_valid_i      (spin_valid),
        .spin_i            (spin_in),
        .spin_ready_o      (spin_ready),
        .spin_o            (spin_out),
        .spin_write_en_o   (spin_write_en),
        .compute_en_o      (compute_en),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .icon_addr_o       (icon_addr),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int len;
        bit last;
    } seg_t;

    seg_t          q[$];
    int            total = 0;
    int            bad = 0;
    logic [NS-1:0] m_spin = '0;
    logic [CW-1:0] m_icon = '0;

    // Packed view of the 1-bit outputs: {busy, done, rv, ready, we, ce}.
    function automatic logic [5:0] flags_now();
        return {busy, done, result_valid, spin_ready, spin_write_en, compute_en};
    endfunction

    function automatic logic [NS-1:0] rand_spin();
        return {$urandom(), $urandom()};
    endfunction

    // Runs one complete sequence with handshake inputs asserted with the given
    // percent probabilities; start and cfg_* are scrambled while the run is busy.
    task automatic run_sequence(input string name, input int w, input int c, input int s,
                                input int last, input bit flip, input bit analog,
                                input int vpct, input int rpct);
        int   ew, ec, el;
        bit   finished;
        seg_t h;
        logic [5:0] ef;
        ew = (w == 0) ? 1 : w;
        ec = (c == 0) ? 1 : c;
        el = (last == 0) ? 1 : last;
        q.delete();
        for (int i = 0; i < el; i++) begin
            if (i == 0 || !flip) q.push_back('{KF, 0, 1'b0});
            if (analog) begin
                q.push_back('{KW, ew, 1'b0});
                q.push_back('{KC, ec, 1'b0});
                if (s != 0) q.push_back('{KS, s, 1'b0});
            end
            q.push_back('{KO, 0, (i == el - 1)});
        end
        q.push_back('{KD, 1, 1'b0});

        @(negedge clk);
        en           = 1'b1;
        start        = 1'b1;
        cyc_write    = CW'(w);
        cyc_compute  = CW'(c);
        sync_num     = CW'(s);
        icon_last    = CW'(last);
        flip_disable = flip;
        analog_en    = analog;
        spin_valid   = ($urandom_range(99) < vpct);
        result_ready = ($urandom_range(99) < rpct);
        spin_in      = rand_spin();
        m_icon       = '0;
        finished     = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (q.size() == 0) ef = '0;
            else begin
                case (q[0].kind)
                    KF:      ef = 6'b100100;
                    KW:      ef = 6'b100010;
                    KC:      ef = 6'b100001;
                    KS:      ef = 6'b100000;
                    KO:      ef = 6'b101000;
                    default: ef = 6'b110000;
                endcase
            end
            total++;
            if (flags_now() !== ef) begin
                bad++;
                $display("FAIL %s flags cyc=%0d got=%b want=%b", name, cyc, flags_now(), ef);
            end
            total++;
            if (icon_addr !== m_icon) begin
                bad++;
                $display("FAIL %s icon_addr cyc=%0d got=%0d want=%0d", name, cyc, icon_addr,
                         m_icon);
            end
            total++;
            if (spin_out !== m_spin) begin
                bad++;
                $display("FAIL %s spin_o cyc=%0d got=%h want=%h", name, cyc, spin_out, m_spin);
            end
            if (q.size() == 0) begin
                finished = 1'b1;
                break;
            end

            spin_valid   = ($urandom_range(99) < vpct);
            result_ready = ($urandom_range(99) < rpct);
            spin_in      = rand_spin();
            start        = ($urandom_range(3) == 0) && (q[0].kind != KD);
            cyc_write    = CW'($urandom_range(9));
            cyc_compute  = CW'($urandom_range(9));
            sync_num     = CW'($urandom_range(9));
            icon_last    = CW'($urandom_range(9));
            flip_disable = $urandom_range(1) == 1;
            analog_en    = $urandom_range(1) == 1;

            h = q[0];
            case (h.kind)
                KF: if (spin_valid) begin
                    m_spin = spin_in;
                    void'(q.pop_front());
                end
                KO: if (result_ready) begin
                    if (!h.last) m_icon = m_icon + 1'b1;
                    void'(q.pop_front());
                end
                KD: void'(q.pop_front());
                default: begin
                    h.len = h.len - 1;
                    if (h.len == 0) void'(q.pop_front());
                    else q[0] = h;
                end
            endcase
        end
        start = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL %s timeout got=busy want=idle", name);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({flags_now(), icon_addr, spin_out} !== '0) begin
            bad++;
            $display("FAIL reset outputs got=%b/%0d/%h want=0", flags_now(), icon_addr,
                     spin_out);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy got=%b want=0", busy);
        end
    endtask

    task automatic test_basic();
        run_sequence("basic", 3, 7, 3, 2, 1'b0, 1'b1, 100, 100);
    endtask

    task automatic test_backpressure();
        bit ok;
        @(negedge clk);
        en = 1'b1; start = 1'b1;
        cyc_write = 1; cyc_compute = 1; sync_num = 1; icon_last = 2;
        flip_disable = 1'b0; analog_en = 1'b1;
        spin_valid = 1'b1; result_ready = 1'b0;
        spin_in = rand_spin();
        m_spin = spin_in;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
        ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (result_valid !== 1'b1 || icon_addr !== '0) ok = 1'b0;
            if (k == 6) result_ready = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL backpressure_hold got=rv%b/icon%0d want=rv1/icon0", result_valid,
                     icon_addr);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || icon_addr !== CW'(1)) begin
            bad++;
            $display("FAIL backpressure_release got=rv%b/icon%0d want=rv0/icon1", result_valid,
                     icon_addr);
        end
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        m_icon = CW'(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_end busy got=%b want=0", busy);
        end
    endtask

    task automatic test_flip_disable();
        run_sequence("flip_disable", 2, 2, 1, 3, 1'b1, 1'b1, 100, 100);
        run_sequence("flip_bypass", 2, 2, 1, 3, 1'b1, 1'b0, 60, 60);
    endtask

    task automatic test_bypass_zero_cfg();
        run_sequence("bypass", 3, 3, 3, 2, 1'b0, 1'b0, 100, 100);
        run_sequence("zero_cfg", 0, 2, 0, 2, 1'b0, 1'b1, 100, 100);
        run_sequence("zero_last", 0, 0, 0, 0, 1'b0, 1'b1, 100, 100);
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk);
        en = 1'b1; start = 1'b1;
        cyc_write = 2; cyc_compute = 6; sync_num = 2; icon_last = 3;
        flip_disable = 1'b0; analog_en = 1'b1;
        spin_valid = 1'b1; result_ready = 1'b1;
        spin_in = rand_spin();
        m_spin = spin_in;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !compute_en; i++) @(negedge clk);
        total++;
        if (compute_en !== 1'b1) begin
            bad++;
            $display("FAIL abort_reach_compute got=%b want=1", compute_en);
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (flags_now() !== '0 || icon_addr !== '0) begin
            bad++;
            $display("FAIL abort_compute got=%b/%0d want=000000/0", flags_now(), icon_addr);
        end
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL abort_quiet got=done/busy seen want=none");
        end

        // Abort coinciding with an output handshake: the handshake is dropped.
        en = 1'b1; start = 1'b1;
        cyc_write = 1; cyc_compute = 1; sync_num = 0; icon_last = 3;
        result_ready = 1'b0;
        spin_in = rand_spin();
        m_spin = spin_in;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
        result_ready = 1'b1;
        en = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || icon_addr !== '0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_output got=busy%b/icon%0d/done%b want=busy0/icon0/done0", busy,
                     icon_addr, done);
        end
        m_icon = '0;
        en = 1'b1;
        run_sequence("after_abort", 2, 2, 2, 2, 1'b0, 1'b1, 80, 80);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        en = 1'b1; start = 1'b1;
        cyc_write = 4; cyc_compute = 3; sync_num = 2; icon_last = 2;
        flip_disable = 1'b0; analog_en = 1'b1;
        spin_valid = 1'b1; result_ready = 1'b1;
        spin_in = rand_spin() | NS'(1);
        @(negedge clk);
        for (int i = 0; i < 20 && !spin_write_en; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({flags_now(), icon_addr, spin_out} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run got=%b/%0d/%h want=0", flags_now(), icon_addr,
                     spin_out);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run_idle got=busy%b/done%b want=0/0", busy, done);
        end
        m_spin = '0;
        m_icon = '0;
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 15; r++) begin
            run_sequence("random", $urandom_range(5), $urandom_range(5), $urandom_range(4),
                         $urandom_range(4), $urandom_range(1) == 1, $urandom_range(3) != 0,
                         $urandom_range(30, 100), $urandom_range(30, 100));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flip_disable();
        test_bypass_zero_cfg();
        test_abort();
        test_reset_mid_run();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
